// File: rtl/arb_pkg.sv
// Shared arbitration definitions: arbitration mode encodings and the
// channel-index width helper used by the arbiter and the mux stage.
package arb_pkg;

   localparam logic ARB_FIXED = 1'b0;
   localparam logic ARB_RR    = 1'b1;

   // Channel-index width; a single channel still needs one bit of index.
   function automatic int sel_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_grant.sv
// Combinational arbiter: one-hot grant plus encoded index. Fixed priority
// scans from channel 0; round-robin scans from ptr, wrapping at N-1.
module rr_grant
   import arb_pkg::*;
#(
   parameter int N    = 4,
   parameter int SELW = sel_w(N)
) (
   input  logic [N-1:0]    req,
   input  logic [SELW-1:0] ptr,
   input  logic            mode,
   output logic [N-1:0]    gnt,
   output logic [SELW-1:0] idx
);

   logic [2*N-1:0] dbl;
   logic [N-1:0]   rot;
   logic           found;
   int             eff_ptr;
   int             off;
   int             sel;

   // Rotate a doubled request vector so the scan start sits at bit 0, take
   // the first set bit, then map the offset back to an absolute channel.
   always_comb begin
      eff_ptr = (mode == ARB_RR) ? int'(ptr) : 0;
      dbl     = {req, req};
      rot     = N'(dbl >> eff_ptr);
      found   = 1'b0;
      off     = 0;
      for (int i = 0; i < N; i++) begin
         if (!found && rot[i]) begin
            found = 1'b1;
            off   = i;
         end
      end
      sel = eff_ptr + off;
      if (sel >= N) sel = sel - N;
      gnt = '0;
      idx = '0;
      for (int j = 0; j < N; j++) begin
         if (found && (j == sel)) gnt[j] = 1'b1;
      end
      if (found) idx = SELW'(sel);
   end

endmodule

// File: rtl/arb_mux_reg.sv
// Registered N-input arbitrating multiplexer with valid/ready handshakes on
// both sides. Grants one channel per cycle and registers its word and index.
module arb_mux_reg
   import arb_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int N     = 4
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 mode,
   input  logic [N*WIDTH-1:0]   in_data,
   input  logic [N-1:0]         in_valid,
   output logic [N-1:0]         in_ready,
   output logic [WIDTH-1:0]     out_data,
   output logic [sel_w(N)-1:0]  out_chan,
   output logic                 out_valid,
   input  logic                 out_ready
);

   localparam int SELW = sel_w(N);

   logic [N-1:0]     gnt;
   logic [SELW-1:0]  gnt_idx;
   logic [SELW-1:0]  rr_ptr;
   logic             load;
   logic             xfer;
   logic [WIDTH-1:0] word_p0;

   logic [WIDTH-1:0] data_p1;
   logic [SELW-1:0]  chan_p1;
   logic             vld_p1;

   rr_grant #(.N(N), .SELW(SELW)) u_grant (
      .req  (in_valid),
      .ptr  (rr_ptr),
      .mode (mode),
      .gnt  (gnt),
      .idx  (gnt_idx)
   );

   // Stage p0: accept when empty or draining; nothing is taken during reset.
   always_comb begin
      load     = !vld_p1 || out_ready;
      in_ready = gnt & {N{load & rstn}};
      xfer     = |in_ready;
      word_p0  = in_data[int'(gnt_idx)*WIDTH +: WIDTH];
   end

   // Stage p1: output register and round-robin pointer advance.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         vld_p1  <= 1'b0;
         data_p1 <= '0;
         chan_p1 <= '0;
         rr_ptr  <= '0;
      end else if (load) begin
         if (xfer) begin
            vld_p1  <= 1'b1;
            data_p1 <= word_p0;
            chan_p1 <= gnt_idx;
            if (mode == ARB_RR) begin
               rr_ptr <= (gnt_idx == SELW'(N-1)) ? '0 : gnt_idx + SELW'(1);
            end
         end else begin
            vld_p1 <= 1'b0;
         end
      end
   end

   assign out_data  = data_p1;
   assign out_chan  = chan_p1;
   assign out_valid = vld_p1;

endmodule
